// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state/owner types and counter width for the memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      BUSY_IF,
      BUSY_MEM,
      DONE_IF,
      DONE_MEM
   } state_t;

   typedef enum logic {
      OWN_IF,
      OWN_MEM
   } owner_t;

   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// mem_wait_counter: loadable down-counter that flags the last cycle of a memory access.
module mem_wait_counter
   import mem_port_arbiter_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_val;
      else if (i_dec && r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between IF and MEM stages.
// Data accesses win arbitration unless the previous owner was MEM and a fetch is waiting.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic [DATA_W-1:0] o_if_rdata,
   output logic              o_if_ready,
   input  logic              i_mem_rd_en,
   input  logic              i_mem_wr_en,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic [DATA_W-1:0] i_mem_wdata,
   output logic [DATA_W-1:0] o_mem_rdata,
   output logic              o_mem_ready,
   output logic              o_ram_en,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata,
   output logic              o_freeze_front,
   output logic              o_freeze_all
);

   state_t            r_state;
   owner_t            r_last;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_we;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_mem_rdata;
   logic              w_dreq;
   logic              w_pick_mem;
   logic              w_grant;
   logic              w_busy;
   logic              w_zero;
   logic              w_mem_ready;
   logic              w_if_ready;

   assign w_dreq     = i_mem_rd_en | i_mem_wr_en;
   assign w_pick_mem = w_dreq & ~((r_last == OWN_MEM) & i_if_req);
   assign w_grant    = (r_state == IDLE) & (w_dreq | i_if_req);
   assign w_busy     = (r_state == BUSY_IF) | (r_state == BUSY_MEM);

   mem_wait_counter u_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_grant),
      .i_val   (CNT_W'(LATENCY - 1)),
      .i_dec   (w_busy),
      .o_zero  (w_zero)
   );

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_last      <= OWN_IF;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_we        <= 1'b0;
         r_if_rdata  <= '0;
         r_mem_rdata <= '0;
      end else begin
         case (r_state)
            IDLE:
               if (w_grant) begin
                  r_addr  <= w_pick_mem ? i_mem_addr : i_if_addr;
                  r_wdata <= i_mem_wdata;
                  r_we    <= w_pick_mem & i_mem_wr_en;
                  r_last  <= w_pick_mem ? OWN_MEM : OWN_IF;
                  r_state <= w_pick_mem ? BUSY_MEM : BUSY_IF;
               end
            BUSY_IF:
               if (w_zero) begin
                  r_if_rdata <= i_ram_rdata;
                  r_state    <= DONE_IF;
               end
            BUSY_MEM:
               if (w_zero) begin
                  if (!r_we)
                     r_mem_rdata <= i_ram_rdata;
                  r_state <= DONE_MEM;
               end
            default: r_state <= IDLE;
         endcase
      end

   assign w_if_ready  = (r_state == DONE_IF);
   assign w_mem_ready = (r_state == DONE_MEM);

   assign o_if_ready     = w_if_ready;
   assign o_mem_ready    = w_mem_ready;
   assign o_if_rdata     = r_if_rdata;
   assign o_mem_rdata    = r_mem_rdata;
   assign o_ram_en       = w_busy;
   assign o_ram_we       = (r_state == BUSY_MEM) & r_we;
   assign o_ram_addr     = r_addr;
   assign o_ram_wdata    = r_wdata;
   // Gated by reset so the pipeline is released the instant reset asserts.
   assign o_freeze_all   = i_rst_n & w_dreq & ~w_mem_ready;
   assign o_freeze_front = (i_rst_n & i_if_req & ~w_if_ready) | o_freeze_all;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench driving a LATENCY=2 and a LATENCY=1 arbiter with shared stimulus,
// checked every cycle against a transaction-level model plus hand-computed literals.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, rd, wr;
   logic [31:0] if_addr, maddr, wdat;
   logic [1:0]  en_w, we_w, ifrdy_w, mrdy_w, fa_w, ff_w;
   logic [31:0] addr_w [2];
   logic [31:0] wd_w [2];
   logic [31:0] ifd_w [2];
   logic [31:0] md_w [2];
   logic [31:0] rdat [2];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < 2; i++) begin : g_dut
      mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2 - i)) u_dut (
         .i_clk          (clk),
         .i_rst_n        (rst_n),
         .i_if_req       (if_req),
         .i_if_addr      (if_addr),
         .o_if_rdata     (ifd_w[i]),
         .o_if_ready     (ifrdy_w[i]),
         .i_mem_rd_en    (rd),
         .i_mem_wr_en    (wr),
         .i_mem_addr     (maddr),
         .i_mem_wdata    (wdat),
         .o_mem_rdata    (md_w[i]),
         .o_mem_ready    (mrdy_w[i]),
         .o_ram_en       (en_w[i]),
         .o_ram_we       (we_w[i]),
         .o_ram_addr     (addr_w[i]),
         .o_ram_wdata    (wd_w[i]),
         .i_ram_rdata    (rdat[i]),
         .o_freeze_front (ff_w[i]),
         .o_freeze_all   (fa_w[i])
      );
   end

   function automatic logic [31:0] memf(logic [31:0] a);
      return 32'h8C010004 ^ ((a ^ 32'h100) * 32'h9E3779B1);
   endfunction

   task automatic chk(string n, int d, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cycle %0d: got %h expected %h", n, d, cyc, got, exp);
      end
   endtask

   // Transaction-level model: a grant at cycle g occupies the port for cycles g+1..g+L,
   // readies at g+L+1, and the port can be re-arbitrated from g+L+2.
   bit          act [2];
   bit          own [2];
   bit          mwe [2];
   bit          last_mem [2];
   int          g [2];
   logic [31:0] ma [2];
   logic [31:0] mwd [2];
   logic [31:0] e_ifd [2];
   logic [31:0] e_md [2];

   initial for (int d = 0; d < 2; d++) rdat[d] = 32'h0;

   always @(negedge clk) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
         int   L;
         logic dreq, en, rdy, e_ifr, e_mr, e_fa, e_ff;
         L    = (d == 0) ? 2 : 1;
         dreq = rd | wr;
         if (!rst_n) begin
            act[d]      = 1'b0;
            last_mem[d] = 1'b0;
            e_ifd[d]    = '0;
            e_md[d]     = '0;
         end else begin
            if (act[d] && cyc == g[d] + L + 2)
               act[d] = 1'b0;
            if (!act[d] && (dreq || if_req)) begin
               own[d]      = dreq && !(last_mem[d] && if_req);
               ma[d]       = own[d] ? maddr : if_addr;
               mwd[d]      = wdat;
               mwe[d]      = own[d] && wr;
               g[d]        = cyc;
               act[d]      = 1'b1;
               last_mem[d] = own[d];
            end
         end
         en  = rst_n && act[d] && cyc > g[d] && cyc <= g[d] + L;
         rdy = rst_n && act[d] && cyc == g[d] + L + 1;
         if (rdy) begin
            if (!own[d]) e_ifd[d] = memf(ma[d]);
            else if (!mwe[d]) e_md[d] = memf(ma[d]);
         end
         rdat[d] = (en && cyc == g[d] + L) ? memf(ma[d]) : (32'hBAD00000 | 32'(cyc));
         e_ifr = rdy && !own[d];
         e_mr  = rdy && own[d];
         e_fa  = rst_n && dreq && !e_mr;
         e_ff  = (rst_n && if_req && !e_ifr) || e_fa;
         chk("ram_en", d, en_w[d], en);
         chk("ram_we", d, we_w[d], en && mwe[d]);
         chk("if_ready", d, ifrdy_w[d], e_ifr);
         chk("mem_ready", d, mrdy_w[d], e_mr);
         chk("if_rdata", d, ifd_w[d], e_ifd[d]);
         chk("mem_rdata", d, md_w[d], e_md[d]);
         chk("freeze_all", d, fa_w[d], e_fa);
         chk("freeze_front", d, ff_w[d], e_ff);
         if (en) chk("ram_addr", d, addr_w[d], ma[d]);
         if (en && mwe[d]) chk("ram_wdata", d, wd_w[d], mwd[d]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; if_req = 0; rd = 0; wr = 0;
      if_addr = '0; maddr = '0; wdat = '0;
      repeat (3) tick();
      at_neg();
      chk("lit_rst_en", 0, en_w[0], 0);
      chk("lit_rst_ifd", 0, ifd_w[0], 0);
      chk("lit_rst_ff", 0, ff_w[0], 0);
      tick(); rst_n = 1'b1;
      repeat (2) tick();
      // fetch at 0x100
      if_req = 1; if_addr = 32'h100;
      at_neg(); chk("lit_t1_ff0", 0, ff_w[0], 1); chk("lit_t1_en0", 0, en_w[0], 0);
      tick(); at_neg(); chk("lit_t1_en1", 0, en_w[0], 1); chk("lit_t1_addr1", 0, addr_w[0], 32'h100);
      tick(); at_neg(); chk("lit_t1_en2", 0, en_w[0], 1); chk("lit_t1_addr2", 0, addr_w[0], 32'h100);
      chk("lit_t1_rdy_l1", 1, ifrdy_w[1], 1); chk("lit_t1_ifd_l1", 1, ifd_w[1], 32'h8C010004);
      tick(); if_req = 0;
      at_neg(); chk("lit_t1_rdy3", 0, ifrdy_w[0], 1); chk("lit_t1_ifd3", 0, ifd_w[0], 32'h8C010004);
      tick(); at_neg(); chk("lit_t1_rdy4", 0, ifrdy_w[0], 0); chk("lit_t1_en4", 0, en_w[0], 0);
      // simultaneous fetch and load, last owner IF
      tick();
      tick(); if_req = 1; if_addr = 32'h104; rd = 1; maddr = 32'h40;
      at_neg(); chk("lit_t2_fa0", 0, fa_w[0], 1);
      tick(); at_neg(); chk("lit_t2_addr1", 0, addr_w[0], 32'h40); chk("lit_t2_we1", 0, we_w[0], 0);
      tick();
      tick(); rd = 0; at_neg(); chk("lit_t2_mrdy3", 0, mrdy_w[0], 1);
      tick(); at_neg(); chk("lit_t2_en4", 0, en_w[0], 0);
      tick(); at_neg(); chk("lit_t2_addr5", 0, addr_w[0], 32'h104);
      tick();
      tick(); if_req = 0; at_neg(); chk("lit_t2_ifrdy7", 0, ifrdy_w[0], 1);
      // continuous store competing with fetch
      repeat (3) tick();
      tick(); wr = 1; if_req = 1; maddr = 32'h80; wdat = 32'h12345678; if_addr = 32'h200;
      tick(); at_neg(); chk("lit_t3_we1", 0, we_w[0], 1); chk("lit_t3_wd1", 0, wd_w[0], 32'h12345678);
      chk("lit_t3_addr1", 0, addr_w[0], 32'h80);
      repeat (2) tick(); at_neg(); chk("lit_t3_mrdy3", 0, mrdy_w[0], 1);
      repeat (2) tick(); at_neg(); chk("lit_t3_we5", 0, we_w[0], 0); chk("lit_t3_addr5", 0, addr_w[0], 32'h200);
      repeat (2) tick(); at_neg(); chk("lit_t3_ifrdy7", 0, ifrdy_w[0], 1);
      repeat (2) tick(); at_neg(); chk("lit_t3_we9", 0, we_w[0], 1); chk("lit_t3_addr9", 0, addr_w[0], 32'h80);
      repeat (2) tick(); at_neg(); chk("lit_t3_mrdy11", 0, mrdy_w[0], 1);
      tick(); wr = 0; if_req = 0;
      // fetch withdrawn mid-access
      repeat (3) tick();
      tick(); if_req = 1; if_addr = 32'h200;
      tick(); if_req = 0; if_addr = 32'h300;
      at_neg(); chk("lit_t4_addr1", 0, addr_w[0], 32'h200);
      tick(); at_neg(); chk("lit_t4_addr2", 0, addr_w[0], 32'h200); chk("lit_t4_en2", 0, en_w[0], 1);
      tick(); at_neg(); chk("lit_t4_rdy3", 0, ifrdy_w[0], 1);
      tick(); at_neg(); chk("lit_t4_en4", 0, en_w[0], 0);
      tick(); at_neg(); chk("lit_t4_en5", 0, en_w[0], 0);
      // asynchronous reset in the middle of a store
      tick(); wr = 1; maddr = 32'h44; wdat = 32'h55AA55AA;
      tick(); at_neg(); chk("lit_t5_en_pre", 0, en_w[0], 1); chk("lit_t5_we_pre", 0, we_w[0], 1);
      #2 rst_n = 1'b0;
      #1;
      chk("lit_t5_en", 0, en_w[0], 0); chk("lit_t5_we", 0, we_w[0], 0);
      chk("lit_t5_mrdy", 0, mrdy_w[0], 0); chk("lit_t5_fa", 0, fa_w[0], 0);
      chk("lit_t5_ff", 0, ff_w[0], 0); chk("lit_t5_en_l1", 1, en_w[1], 0);
      tick(); wr = 0;
      tick();
      tick(); rst_n = 1'b1;
      tick(); at_neg(); chk("lit_t5_idle1", 0, en_w[0], 0);
      tick(); at_neg(); chk("lit_t5_idle2", 0, en_w[0], 0); chk("lit_t5_ifd", 0, ifd_w[0], 0);
      chk("lit_t5_md", 0, md_w[0], 0);
      // LATENCY=1 read+write collision is a write
      tick(); rd = 1; wr = 1; maddr = 32'h10; wdat = 32'hDEADBEEF;
      at_neg(); chk("lit_t6_en0", 1, en_w[1], 0);
      tick(); at_neg(); chk("lit_t6_en1", 1, en_w[1], 1); chk("lit_t6_we1", 1, we_w[1], 1);
      chk("lit_t6_wd1", 1, wd_w[1], 32'hDEADBEEF); chk("lit_t6_addr1", 1, addr_w[1], 32'h10);
      tick(); rd = 0; wr = 0;
      at_neg(); chk("lit_t6_mrdy2", 1, mrdy_w[1], 1); chk("lit_t6_en2", 1, en_w[1], 0);
      chk("lit_t6_md2", 1, md_w[1], 0);
      tick(); at_neg(); chk("lit_t6_mrdy3", 1, mrdy_w[1], 0);
      repeat (4) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Grants one owner at a time and holds the memory signals stable for LATENCY cycles.
- Returns data and a one-cycle ready pulse to the owner.
- Drives the freeze signals that stall the front end or the whole pipeline while requests wait.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LATENCY, 2, memory access cycles per transaction; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction fetch request, level.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction.
- if_ready  out  1  fetch complete, 1-cycle pulse.
- mem_rd_en  in  1  load request, level.
- mem_wr_en  in  1  store request, level.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data.
- mem_ready  out  1  data access complete, 1-cycle pulse.
- ram_en  out  1  memory enable.
- ram_we  out  1  memory write enable.
- ram_addr  out  ADDR_W  memory address.
- ram_wdata  out  DATA_W  memory write data.
- ram_rdata  in  DATA_W  memory read data, valid in the last access cycle.
- freeze_front  out  1  hold PC and IF2ID.
- freeze_all  out  1  hold every pipeline register.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; counter=0; last_owner=IF.
  - All outputs 0, including ram_en/ram_we immediately, even mid-transaction.
  - if_rdata and mem_rdata clear to 0.
- States: IDLE, BUSY_IF, BUSY_MEM, DONE_IF, DONE_MEM.
- Arbitration, evaluated in IDLE only:
  - Data request = mem_rd_en|mem_wr_en.
  - Data wins over if_req, except when last_owner=MEM and if_req=1; then IF wins. This prevents fetch starvation.
  - On grant: latch addr, wdata, kind (read/write) and owner; load counter=LATENCY-1; go to BUSY_x; update last_owner.
- BUSY_x:
  - ram_en=1; ram_addr/ram_wdata/ram_we come from the latched values and stay constant for the whole transaction.
  - Counter decrements each cycle.
  - When counter=0: capture ram_rdata into if_rdata (IF) or into mem_rdata (data read only); go to DONE_x.
  - Latency from grant edge to ready is LATENCY+1 cycles.
- DONE_x:
  - Assert if_ready or mem_ready for exactly this cycle; ram_en=0.
  - Next state is always IDLE. This forces a one-cycle bubble so a stale level request is not re-served.
- Writes:
  - Both mem_rd_en and mem_wr_en high: treated as a write (ram_we=1).
  - A write pulses mem_ready; mem_rdata is held unchanged.
- Read data: if_rdata and mem_rdata hold their values until the next capture for the same owner.
- Request withdrawn mid-transaction (flush, branch_taken): the access is not aborted; it runs to completion and the ready pulse is still issued. The requester ignores it.
- Latched values: address or data changes during BUSY are ignored.
- Freeze outputs (combinational from registered state plus current requests):
  - freeze_all = (mem_rd_en|mem_wr_en) & ~mem_ready.
  - freeze_front = (if_req & ~if_ready) | freeze_all.
- LATENCY=1: BUSY lasts one cycle (counter loads 0).

Decomposition:
- Shared package holds:
  - State enum: IDLE, BUSY_IF, BUSY_MEM, DONE_IF, DONE_MEM, 3 bits.
  - Owner enum: OWN_IF, OWN_MEM.
  - CNT_W derivation constant, 4 bits.
- One sub-module, mem_wait_counter, handles load/decrement/zero-flag for the latency count.
- Arbitration and FSM stay in the top module.

Test Plan:
1. Reset then if_req=1, if_addr=0x100, ram returns 0x8C010004, LATENCY=2:
   - ram_en high for cycles 1-2 with ram_addr=0x100.
   - if_ready pulses in cycle 3 with if_rdata=0x8C010004.
   - freeze_front=1 in cycles 0-2.
2. if_req and mem_rd_en both raised in IDLE, last_owner=IF, mem_addr=0x40:
   - MEM is granted first: ram_addr=0x40, freeze_all=1.
   - After mem_ready, IDLE, then the IF grant follows.
3. mem_wr_en held continuously with if_req=1:
   - Grants alternate MEM, IF, MEM.
   - ram_we=1 only during MEM transactions; mem_rdata unchanged by writes.
4. Start a fetch at 0x200, then drop if_req and change if_addr to 0x300 mid-BUSY:
   - ram_addr stays 0x200 for all LATENCY cycles.
   - if_ready still pulses once.
   - Next grant occurs only if a request is present in IDLE.
5. Assert rst=0 asynchronously during BUSY_MEM:
   - ram_en, ram_we, mem_ready and the freeze outputs drop without waiting for a clock edge.
   - After release, the block idles until a new request arrives.
6. LATENCY=1, mem_rd_en=1 and mem_wr_en=1 together at addr 0x10, wdata 0xDEADBEEF:
   - One cycle with ram_we=1 and ram_wdata=0xDEADBEEF.
   - mem_ready pulses on the next cycle.
